req_priority_encoder: RTL and testbench
=======================================

Name: req_priority_encoder

Overview:
- Parametrised, registered priority encoder with request queuing: N one-hot/multi-hot request lines are captured into a pending register.
- Pending requests are issued one at a time as binary indices over a valid/ready handshake, highest priority first.
- Each issued request clears its pending bit.
- Sits between request sources (interrupt/event lines) and a consumer that accepts one encoded index per transfer.

Parameters:
- N, 8, number of request lines (>=2)
- W, 3, index width; must equal ceil(log2(N))
- MSB_FIRST, 1, 1 = highest bit index has priority; 0 = bit 0 has priority

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_in  input  N  request vector, sampled only when req_load=1
- req_load  input  1  capture strobe for req_in
- out_idx  output  W  encoded index of the issued request
- out_valid  output  1  out_idx holds a valid request
- out_ready  input  1  consumer accepts out_idx when out_valid & out_ready
- pending  output  N  current pending register (not yet issued)
- busy  output  1  out_valid | (pending != 0)
- overflow  output  1  one-cycle pulse: a loaded bit was already set in pending

Behaviour:
- Reset: the condition is rst=1 at a clk edge. It sets pending=0, out_idx=0, out_valid=0, overflow=0 and busy=0. Reset overrides all other activity, including mid-handshake; a held output is dropped without transfer.
- Internal: merged vector M = pending | (req_load ? req_in : 0), evaluated each cycle.
- Slot free condition: slot_free = ~out_valid | out_ready.
- When slot_free and M != 0, at the clk edge:
  - out_idx <= index of the priority bit of M (highest set bit if MSB_FIRST=1, else lowest).
  - out_valid <= 1.
  - pending <= M with that bit cleared.
- When slot_free and M == 0: out_valid <= 0, out_idx holds its last value, pending <= 0.
- When not slot_free (out_valid=1, out_ready=0):
  - out_idx and out_valid hold stable.
  - pending <= M.
  - A higher-priority arrival does not pre-empt the held index.
- Latency: a request loaded at edge k appears on out_idx/out_valid after edge k if the slot is free (1-cycle latency).
- Back-to-back issue: one index per cycle with out_ready held high; N simultaneous requests drain in N cycles.
- overflow <= 1 for one cycle when req_load=1 and (req_in & pending) != 0, otherwise 0. A duplicate request is merged, never counted twice.
- A bit equal to the index currently held in the slot is not a duplicate. It is set in pending and issued again later.
- req_in bits are ignored when req_load=0.
- busy is combinational from the registers: busy = out_valid | (pending != 0).
- All widths are fixed at W for out_idx; no arithmetic overflow is possible.

Test Plan:
- N=8, MSB_FIRST=1, out_ready=1; load req_in=8'b1010_0100 at one edge -> out_idx 7, 5, 2 on three consecutive cycles with out_valid=1, then out_valid=0 and busy=0.
- Same stimulus with MSB_FIRST=0 -> order 2, 5, 7.
- Hold out_ready=0 after out_idx=5 is issued; load req_in=8'h80 -> out_idx stays 5, pending=8'h84. Release out_ready -> next outputs are 7, then 2.
- pending=8'h04; load req_in=8'h0C with out_ready=0 -> overflow pulses 1 for exactly one cycle; pending=8'h0C; bit 2 is later issued once only.
- Apply rst=1 mid-drain (pending=8'h21, out_valid=1) -> after the edge, all outputs are 0. The first load after reset (req_in=8'h01) gives out_idx=0, out_valid=1 one edge later.
- N=4, W=2, MSB_FIRST=1; load 4'b1111 with out_ready=1 -> sequence 3, 2, 1, 0.

Source files
------------

// File: rtl/req_priority_encoder.sv
// req_priority_encoder: queues multi-hot requests in a pending register and issues them
// one index per valid/ready transfer, highest priority first.
module req_priority_encoder #(
   parameter int N         = 8,
   parameter int W         = 3,
   parameter int MSB_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         req_load,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] pending,
   output logic         busy,
   output logic         overflow
);
   logic [N-1:0] pend_q, pend_d, merged;
   logic [W-1:0] idx_q, idx_d, pick;
   logic         vld_q, vld_d, ovf_q, ovf_d, slot_free;
   assign merged    = pend_q | (req_load ? req_in : '0);
   assign slot_free = ~vld_q | out_ready;
   // The scan runs toward the priority end so the last hit is the winner.
   always_comb begin
      pick = '0;
      for (int i = 0; i < N; i++)
         if (merged[MSB_FIRST != 0 ? i : N-1-i]) pick = W'(MSB_FIRST != 0 ? i : N-1-i);
   end
   always_comb begin
      pend_d = slot_free ? (merged & ~({{(N-1){1'b0}}, 1'b1} << pick)) : merged;
      vld_d  = slot_free ? |merged : vld_q;
      idx_d  = (slot_free && |merged) ? pick : idx_q;
      ovf_d  = req_load & |(req_in & pend_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         idx_q  <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         idx_q  <= idx_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
      end
   end
   assign out_idx   = idx_q;
   assign out_valid = vld_q;
   assign pending   = pend_q;
   assign overflow  = ovf_q;
   assign busy      = vld_q | (|pend_q);
endmodule

// File: tb/tb_req_priority_encoder.sv
// tb_req_priority_encoder: three configurations driven by shared directed stimulus,
// checked every cycle against an arithmetic model plus literal spot checks.
module tb_req_priority_encoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;
   logic       ld = 1'b0;
   logic       rdy = 1'b1;
   logic       armed = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic [2:0] idx_a; logic [7:0] pend_a; logic vld_a, busy_a, ovf_a;
   logic [2:0] idx_b; logic [7:0] pend_b; logic vld_b, busy_b, ovf_b;
   logic [1:0] idx_c; logic [3:0] pend_c; logic vld_c, busy_c, ovf_c;

   always #5 clk = ~clk;

   req_priority_encoder #(.N(8), .W(3), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .req_in(req), .req_load(ld), .out_idx(idx_a), .out_valid(vld_a),
      .out_ready(rdy), .pending(pend_a), .busy(busy_a), .overflow(ovf_a));
   req_priority_encoder #(.N(8), .W(3), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .req_in(req), .req_load(ld), .out_idx(idx_b), .out_valid(vld_b),
      .out_ready(rdy), .pending(pend_b), .busy(busy_b), .overflow(ovf_b));
   req_priority_encoder #(.N(4), .W(2), .MSB_FIRST(1)) u_n4 (
      .clk(clk), .rst(rst), .req_in(req[3:0]), .req_load(ld), .out_idx(idx_c), .out_valid(vld_c),
      .out_ready(rdy), .pending(pend_c), .busy(busy_c), .overflow(ovf_c));

   typedef struct packed {
      logic [7:0] pend;
      logic [7:0] idx;
      logic       vld;
      logic       ovf;
   } mstate_t;

   mstate_t ms [3];
   initial for (int k = 0; k < 3; k++) ms[k] = '0;

   // Priority bit from integer arithmetic: top bit via clog2(m+1)-1, bottom bit via clog2(m & -m).
   function automatic mstate_t nxt(mstate_t s, int n, bit msb, logic [7:0] rin, logic l, logic r, logic rs);
      mstate_t o;
      int m, in_m, b;
      if (rs) return '0;
      in_m = l ? (int'(rin) & ((1 << n) - 1)) : 0;
      m = int'(s.pend) | in_m;
      o = s;
      o.ovf = (in_m & int'(s.pend)) != 0;
      if (!s.vld || r) begin
         if (m == 0) begin
            o.vld = 1'b0;
            o.pend = '0;
         end else begin
            b = msb ? $clog2(m + 1) - 1 : $clog2(m & -m);
            o.idx = 8'(b);
            o.vld = 1'b1;
            o.pend = 8'(m - (1 << b));
         end
      end else o.pend = 8'(m);
      return o;
   endfunction

   always @(posedge clk) begin
      ms[0] <= nxt(ms[0], 8, 1'b1, req, ld, rdy, rst);
      ms[1] <= nxt(ms[1], 8, 1'b0, req, ld, rdy, rst);
      ms[2] <= nxt(ms[2], 4, 1'b1, req, ld, rdy, rst);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input string tag, input mstate_t s, input int idx, input int vld,
                           input int pend, input int busy, input int ovf);
      if (s.vld) check({tag, ".idx"}, idx, int'(s.idx));
      check({tag, ".valid"}, vld, int'(s.vld));
      check({tag, ".pending"}, pend, int'(s.pend));
      check({tag, ".busy"}, busy, int'(s.vld || s.pend != 0));
      check({tag, ".overflow"}, ovf, int'(s.ovf));
   endtask

   always @(negedge clk) begin
      if (armed) begin
         cmp_inst("msb", ms[0], int'(idx_a), int'(vld_a), int'(pend_a), int'(busy_a), int'(ovf_a));
         cmp_inst("lsb", ms[1], int'(idx_b), int'(vld_b), int'(pend_b), int'(busy_b), int'(ovf_b));
         cmp_inst("n4", ms[2], int'(idx_c), int'(vld_c), int'(pend_c), int'(busy_c), int'(ovf_c));
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [7:0] v);
      req = v;
      ld = 1'b1;
      tick();
      ld = 1'b0;
      req = '0;
   endtask

   initial begin
      @(negedge clk);
      tick();
      rst = 1'b0;
      armed = 1'b1;
      check("rst_idx", int'(idx_a), 0);
      check("rst_valid", int'(vld_a), 0);
      check("rst_busy", int'(busy_a), 0);
      // Basic drain, both priority orders
      load(8'hA4);
      check("d1_msb", int'(idx_a), 7);
      check("d1_lsb", int'(idx_b), 2);
      tick();
      check("d2_msb", int'(idx_a), 5);
      check("d2_lsb", int'(idx_b), 5);
      tick();
      check("d3_msb", int'(idx_a), 2);
      check("d3_lsb", int'(idx_b), 7);
      tick();
      check("d4_valid", int'(vld_a), 0);
      check("d4_busy", int'(busy_a), 0);
      // Held slot is not pre-empted by a higher-priority arrival
      load(8'hA4);
      tick();
      check("h_issue5", int'(idx_a), 5);
      rdy = 1'b0;
      load(8'h80);
      check("h_hold5", int'(idx_a), 5);
      check("h_pend", int'(pend_a), 8'h84);
      tick();
      check("h_still5", int'(idx_a), 5);
      rdy = 1'b1;
      tick();
      check("h_next7", int'(idx_a), 7);
      tick();
      check("h_next2", int'(idx_a), 2);
      tick();
      check("h_idle", int'(vld_a), 0);
      // Duplicate request: bit 2 merges, bit 3 equals the held index and is re-queued
      load(8'h0C);
      check("o_idx3", int'(idx_a), 3);
      check("o_pend04", int'(pend_a), 8'h04);
      rdy = 1'b0;
      load(8'h0C);
      check("o_pulse", int'(ovf_a), 1);
      check("o_pend0c", int'(pend_a), 8'h0C);
      tick();
      check("o_clear", int'(ovf_a), 0);
      rdy = 1'b1;
      tick();
      check("o_re3", int'(idx_a), 3);
      tick();
      check("o_once2", int'(idx_a), 2);
      tick();
      check("o_done", int'(busy_a), 0);
      // Reset mid-drain drops everything
      load(8'h61);
      check("r_idx6", int'(idx_a), 6);
      check("r_pend21", int'(pend_a), 8'h21);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("r_valid", int'(vld_a), 0);
      check("r_pend", int'(pend_a), 0);
      check("r_idx", int'(idx_a), 0);
      load(8'h01);
      check("r_first_idx", int'(idx_a), 0);
      check("r_first_vld", int'(vld_a), 1);
      tick();
      // Ignored input without load strobe
      req = 8'hFF;
      tick();
      req = 8'h00;
      check("noload_busy", int'(busy_a), 0);
      // N=4 full drain
      load(8'h0F);
      check("n4_3", int'(idx_c), 3);
      tick();
      check("n4_2", int'(idx_c), 2);
      tick();
      check("n4_1", int'(idx_c), 1);
      tick();
      check("n4_0", int'(idx_c), 0);
      tick();
      check("n4_idle", int'(vld_c), 0);
      tick();
      armed = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
